// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file's single write port (pipeline A vs long-latency B),
// plus a pending-destination scoreboard that drives the decode-stage hazard stall.
module wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_wa,
  input  logic [31:0] a_wd,
  output logic        a_stall,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_wa,
  input  logic [31:0] b_wd,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wa,
  output logic        iss_ready,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        id_we,
  input  logic [4:0]  id_wa,
  output logic        hazard,
  output logic        writeReg,
  output logic [4:0]  wa,
  output logic [31:0] wd
);

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;
  localparam int unsigned SW    = 4;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;
  logic [SW-1:0]   starve;
  logic [SW-1:0]   starve_n;
  logic            from_b;
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_n;

  logic            fifo_nempty;
  logic            push;
  logic            pop;
  logic            force_b;
  logic            grant_a;
  logic            grant_b;
  logic [AW-1:0]   win_wa;
  logic [DW-1:0]   win_wd;
  logic            iss_set;
  entry_t          head;

  // Grant selection: forced B when A has starved it, else A, else B.
  always_comb begin
    head        = fifo_q[rd_ptr];
    fifo_nempty = (count != '0);
    b_ready     = (count != FULL_CNT);
    push        = b_valid && b_ready;
    force_b     = (starve == STARVE_LIM) && fifo_nempty;
    grant_a     = a_valid && !force_b;
    grant_b     = force_b || (!a_valid && fifo_nempty);
    pop         = grant_b;
    a_stall     = force_b;
    win_wa      = grant_b ? head.wa : a_wa;
    win_wd      = grant_b ? head.wd : a_wd;
  end

  // FIFO occupancy and starvation counter next state.
  always_comb begin
    count_n  = count;
    starve_n = starve;
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
    if (!fifo_nempty || grant_b) begin
      starve_n = '0;
    end else if (grant_a && (starve != STARVE_LIM)) begin
      starve_n = starve + SW'(1);
    end
  end

  // Scoreboard: set on accepted issue, clear when a B result reaches the register file.
  always_comb begin
    iss_ready = !((iss_wa != '0) && pend[iss_wa]);
    iss_set   = iss_valid && iss_ready && (iss_wa != '0);
    pend_n    = pend;
    if (writeReg && from_b) begin
      pend_n[wa] = 1'b0;
    end
    if (iss_set) begin
      pend_n[iss_wa] = 1'b1;
    end
    pend_n[0] = 1'b0;
    hazard = pend[ra1] || pend[ra2] || (id_we && pend[id_wa]) || a_stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      starve <= '0;
      pend   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{wa: b_wa, wd: b_wd};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count  <= count_n;
      starve <= starve_n;
      pend   <= pend_n;
    end
  end

  // Output register; a $0 destination is consumed without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeReg <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      from_b   <= 1'b0;
    end else if ((grant_a || grant_b) && (win_wa != '0)) begin
      writeReg <= 1'b1;
      wa       <= win_wa;
      wd       <= win_wd;
      from_b   <= grant_b;
    end else begin
      writeReg <= 1'b0;
      from_b   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (STARVE_MAX = 4).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic        a_stall;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic        iss_valid;
  logic [4:0]  iss_wa;
  logic        iss_ready;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        id_we;
  logic [4:0]  id_wa;
  logic        hazard;
  logic        writeReg;
  logic [4:0]  wa;
  logic [31:0] wd;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd), .a_stall(a_stall),
    .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
    .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_ready(iss_ready),
    .ra1(ra1), .ra2(ra2), .id_we(id_we), .id_wa(id_wa), .hazard(hazard),
    .writeReg(writeReg), .wa(wa), .wd(wd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] ea, input logic [31:0] ed);
    chk({tag, ".we"}, 32'(writeReg), 32'd1);
    chk({tag, ".wa"}, 32'(wa), 32'(ea));
    chk({tag, ".wd"}, wd, ed);
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; a_wa = '0; a_wd = '0;
    b_valid = 1'b0; b_wa = '0; b_wd = '0;
    iss_valid = 1'b0; iss_wa = '0; ra1 = '0; ra2 = '0; id_we = 1'b0; id_wa = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_we", 32'(writeReg), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_bready", 32'(b_ready), 32'd1);
    chk("rst_issready", 32'(iss_ready), 32'd1);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_astall", 32'(a_stall), 32'd0);

    // A-only stream
    a_valid = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF;
    tick();
    chk_wr("a_wr", 5'd5, 32'hDEADBEEF);
    a_wa = 5'd0; a_wd = 32'h1;
    tick();
    chk("a_r0_we", 32'(writeReg), 32'd0);
    chk("a_r0_hold_wa", 32'(wa), 32'd5);
    chk("a_r0_hold_wd", wd, 32'hDEADBEEF);
    a_valid = 1'b0;
    tick();
    chk("a_idle_we", 32'(writeReg), 32'd0);

    // Scoreboard round trip on $7
    iss_valid = 1'b1; iss_wa = 5'd7;
    #1 chk("sb_iss_rdy0", 32'(iss_ready), 32'd1);
    tick();
    iss_valid = 1'b0; ra1 = 5'd7;
    #1;
    chk("sb_iss_rdy1", 32'(iss_ready), 32'd0);
    chk("sb_hazard_set", 32'(hazard), 32'd1);
    chk("sb_pend7", dut.pend, 32'h0000_0080);
    b_valid = 1'b1; b_wa = 5'd7; b_wd = 32'h1234;
    tick();
    b_valid = 1'b0;
    tick();
    chk_wr("sb_b_wr", 5'd7, 32'h1234);
    chk("sb_hazard_commit", 32'(hazard), 32'd1);
    tick();
    chk("sb_hazard_clr", 32'(hazard), 32'd0);
    chk("sb_iss_rdy2", 32'(iss_ready), 32'd1);
    chk("sb_idle_we", 32'(writeReg), 32'd0);
    ra1 = 5'd0;

    // Starvation: 4 A grants while B waits, then forced B
    a_valid = 1'b1; a_wa = 5'd10; a_wd = 32'hAAAA;
    b_valid = 1'b1; b_wa = 5'd12; b_wd = 32'hBBBB;
    tick();
    b_valid = 1'b0;
    chk_wr("st_a0", 5'd10, 32'hAAAA);
    for (int i = 0; i < 4; i++) begin
      chk("st_nostall", 32'(a_stall), 32'd0);
      tick();
      chk_wr("st_a", 5'd10, 32'hAAAA);
    end
    chk("st_stall", 32'(a_stall), 32'd1);
    chk("st_stall_hazard", 32'(hazard), 32'd1);
    tick();
    chk_wr("st_b", 5'd12, 32'hBBBB);
    chk("st_resume_nostall", 32'(a_stall), 32'd0);
    tick();
    chk_wr("st_a_resume", 5'd10, 32'hAAAA);

    // FIFO full with A busy; third push held until first B grant
    b_valid = 1'b1; b_wa = 5'd20; b_wd = 32'd1;
    #1 chk("ff_rdy0", 32'(b_ready), 32'd1);
    tick();
    b_wa = 5'd21; b_wd = 32'd2;
    #1 chk("ff_rdy1", 32'(b_ready), 32'd1);
    tick();
    b_wa = 5'd22; b_wd = 32'd3;
    #1 chk("ff_full", 32'(b_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr("ff_a", 5'd10, 32'hAAAA);
      chk("ff_full_hold", 32'(b_ready), 32'd0);
    end
    chk("ff_stall", 32'(a_stall), 32'd1);
    tick();
    chk_wr("ff_b20", 5'd20, 32'd1);
    chk("ff_rdy_after", 32'(b_ready), 32'd1);
    a_valid = 1'b0;
    tick();
    b_valid = 1'b0;
    chk_wr("ff_b21", 5'd21, 32'd2);
    tick();
    chk_wr("ff_b22", 5'd22, 32'd3);
    tick();
    chk("ff_idle", 32'(writeReg), 32'd0);

    // Same-cycle commit on $3 and issue to $9
    iss_valid = 1'b1; iss_wa = 5'd3;
    tick();
    iss_valid = 1'b0;
    b_valid = 1'b1; b_wa = 5'd3; b_wd = 32'h33;
    tick();
    b_valid = 1'b0;
    tick();
    chk_wr("sc_b3", 5'd3, 32'h33);
    iss_valid = 1'b1; iss_wa = 5'd9;
    #1 chk("sc_iss9_rdy", 32'(iss_ready), 32'd1);
    tick();
    iss_valid = 1'b0;
    chk("sc_pend", dut.pend, 32'h0000_0200);
    ra1 = 5'd3;
    #1 chk("sc_hz_r3", 32'(hazard), 32'd0);
    ra2 = 5'd9;
    #1 chk("sc_hz_r9", 32'(hazard), 32'd1);
    ra2 = 5'd0; id_we = 1'b1; id_wa = 5'd9;
    #1 chk("sc_hz_waw", 32'(hazard), 32'd1);
    id_we = 1'b0;
    #1 chk("sc_hz_nowe", 32'(hazard), 32'd0);
    iss_valid = 1'b1; iss_wa = 5'd0;
    #1 chk("sc_iss_r0_rdy", 32'(iss_ready), 32'd1);
    tick();
    iss_valid = 1'b0;
    chk("sc_pend_r0", dut.pend, 32'h0000_0200);

    // Reset with FIFO full and pend = 0x0F00
    for (int r = 8; r <= 11; r++) begin
      iss_valid = 1'b1; iss_wa = 5'(r);
      tick();
    end
    iss_valid = 1'b0;
    chk("rs_pend_pre", dut.pend, 32'h0000_0F00);
    a_valid = 1'b1; a_wa = 5'd1; a_wd = 32'h11;
    b_valid = 1'b1; b_wa = 5'd8; b_wd = 32'h88;
    tick();
    b_wa = 5'd10; b_wd = 32'hA0;
    tick();
    b_valid = 1'b0;
    #1 chk("rs_full", 32'(b_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; a_valid = 1'b0; ra1 = 5'd9; ra2 = 5'd8;
    #1;
    chk("rs_we", 32'(writeReg), 32'd0);
    chk("rs_bready", 32'(b_ready), 32'd1);
    chk("rs_pend", dut.pend, 32'd0);
    chk("rs_hazard", 32'(hazard), 32'd0);
    tick();
    chk("rs_no_write1", 32'(writeReg), 32'd0);
    tick();
    chk("rs_no_write2", 32'(writeReg), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and scoreboard for the 32-entry register file. It shares the register file's single write port between two requesters: the main pipeline write-back stage (A) and a long-latency unit such as mult/div or a late load (B). It tracks destination registers with pending B results so that the decode stage can stall on RAW and WAW hazards. It sits between the pipeline and the register file and drives the register file's `writeReg`, `wa` and `wd` inputs directly.

## Interface
- `STARVE_MAX`, default 4: consecutive A grants allowed while B has data waiting before A is stalled. Legal range 1..15.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `a_valid`  in  1  pipeline write-back request.
- `a_wa`  in  5  pipeline destination register.
- `a_wd`  in  32  pipeline write data.
- `a_stall`  out  1  pipeline must hold its write-back stage (`a_valid`, `a_wa`, `a_wd` stable).
- `b_valid`  in  1  long-latency result valid.
- `b_ready`  out  1  result FIFO can accept.
- `b_wa`  in  5  long-latency destination.
- `b_wd`  in  32  long-latency data.
- `iss_valid`  in  1  long-latency op issued, reserving `iss_wa`.
- `iss_wa`  in  5  destination being reserved.
- `iss_ready`  out  1  reservation is accepted this cycle.
- `ra1`, `ra2`  in  5 each  decode source registers.
- `id_we`  in  1  decode instruction writes a register.
- `id_wa`  in  5  decode destination.
- `hazard`  out  1  decode must stall.
- `writeReg`  out  1  register file write enable (registered).
- `wa`  out  5  register file write address (registered).
- `wd`  out  32  register file write data (registered).

## Operation
- **B FIFO.** Depth 2, holding {wa, wd}.
  - Push when `b_valid && b_ready`.
  - `b_ready = (count != 2)`.
  - Push and pop in the same cycle while full is not possible, because `b_ready` is 0. Push and pop in the same cycle otherwise keeps `count`.
- **Grant each cycle.**
  - If `starve == STARVE_MAX` and the FIFO is non-empty: grant B and assert `a_stall`.
  - Otherwise, if `a_valid`: grant A.
  - Otherwise, if the FIFO is non-empty: grant B.
  - Otherwise: idle.
- **Starvation counter** (4 bits).
  - Increments when A is granted while the FIFO is non-empty.
  - Clears on any B grant or when the FIFO is empty.
  - Saturates at `STARVE_MAX`.
- **`a_stall`** is asserted only in the forced-B case. A is not consumed in that cycle.
- **Register `$0`.** A granted request with `wa == 0` is consumed, but the next cycle has `writeReg = 0`. A B entry to `$0` cannot exist, because issue to `$0` is never reserved.
- **Output register.**
  - On a grant with non-zero address: `writeReg <= 1`, `wa` and `wd` take the winner's values, and an internal `from_b` flag is set if B won.
  - Otherwise `writeReg <= 0`; `wa` and `wd` hold their values.
- **Scoreboard.** 32-bit `pend` vector; bit 0 is always 0.
  - `iss_ready = !(iss_wa != 0 && pend[iss_wa])`.
  - On `iss_valid && iss_ready && iss_wa != 0`, set `pend[iss_wa]`.
  - At the edge where `writeReg && from_b`, clear `pend[wa]`. This is the edge on which the register file latches the data.
  - Set and clear on different registers in the same cycle: both apply.
  - The same register cannot be set and cleared in one cycle, because `iss_ready` is 0 while the bit is pending.
- **`hazard`** (combinational) is high when any of these holds:
  - `pend[ra1]`
  - `pend[ra2]`
  - `id_we && pend[id_wa]`
  - `a_stall`

## Timing
- **Reset.** In the cycle after the `rst` edge:
  - `writeReg=0`, `wa=0`, `wd=0`.
  - FIFO empty, so `b_ready=1`.
  - `pend=0`, `starve=0`, so `a_stall=0`, `hazard=0` (with `pend` clear) and `iss_ready=1`.
- **Reset mid-operation.** FIFO contents and any in-flight output write are dropped; no write occurs after the reset edge.
- **Latency.**
  - Grant to register-file commit: 2 edges (output register, then the register file).
  - B push to earliest grant: 1 cycle, since a FIFO entry is visible the cycle after push. There is no same-cycle bypass.
- **Reads after a B commit.** A decode read of a B-written register is unblocked in the cycle after the commit edge, when the register file already holds the new value.
- **Throughput.** One write per cycle, sustained.
- **B bandwidth.** With A valid every cycle, B gets at least 1 grant per `STARVE_MAX+1` cycles.

## Test plan
- **Reset.** Assert `rst` with FIFO full and `pend=0x0000_0F00` -> next cycle `writeReg=0`, `b_ready=1`, `pend=0`, `hazard=0`.
- **A-only stream.** `a_valid`, `a_wa=5`, `a_wd=0xDEADBEEF` -> next cycle `writeReg=1`, `wa=5`, `wd=0xDEADBEEF`. With `a_wa=0` -> `writeReg=0`.
- **Scoreboard round-trip.**
  - Issue `iss_wa=7` -> `pend[7]=1`, so `ra1=7` gives `hazard=1` and a second issue to 7 gives `iss_ready=0`.
  - B pushes `{7, 0x1234}` -> granted the next cycle, `writeReg=1`, `wa=7`, `from_b`.
  - `pend[7]` clears at the following edge, and `hazard` drops that cycle.
- **Starvation.** `STARVE_MAX=4`, A valid continuously, B pushes one entry -> A is granted for 4 cycles, then `a_stall=1` and B is written, then A resumes holding the same `a_wa`/`a_wd`.
- **FIFO full.** Three back-to-back B pushes while A is valid -> `b_ready=0` after 2 entries. The third push is held by `b_valid` and accepted after the first B grant. All three are written in order.
- **Same-cycle issue and commit, different registers.** Commit on register 3 and issue to register 9 in one cycle -> `pend[3]=0` and `pend[9]=1` the next cycle.
